// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding used by the decoder, RS and execution
// pipes, plus the datapath result width.
package alu_pkg;
    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NE   = 4'd11;
    localparam logic [3:0] ALU_LT   = 4'd12;
    localparam logic [3:0] ALU_GE   = 4'd13;
    localparam logic [3:0] ALU_LTU  = 4'd14;
    localparam logic [3:0] ALU_GEU  = 4'd15;
endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU: {opcode, lhs, rhs} -> value. Holds no state; the pipe
// wrapper registers the result.
module alu_datapath
    import alu_pkg::*;
(
    input  logic [3:0]      opcode,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    output logic [XLEN-1:0] value
);
    logic [4:0] shamt;
    logic       lt_s, lt_u, eq;

    assign shamt = rhs[4:0];
    assign lt_s  = $signed(lhs) < $signed(rhs);
    assign lt_u  = lhs < rhs;
    assign eq    = lhs == rhs;

    // One shared comparator set feeds every compare opcode.
    always_comb begin
        value = '0;
        case (opcode)
            ALU_ADD:  value = lhs + rhs;
            ALU_SUB:  value = lhs - rhs;
            ALU_SLL:  value = lhs << shamt;
            ALU_SLT:  value = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: value = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  value = lhs ^ rhs;
            ALU_SRL:  value = lhs >> shamt;
            ALU_SRA:  value = $unsigned($signed(lhs) >>> shamt);
            ALU_OR:   value = lhs | rhs;
            ALU_AND:  value = lhs & rhs;
            ALU_EQ:   value = {{(XLEN-1){1'b0}}, eq};
            ALU_NE:   value = {{(XLEN-1){1'b0}}, ~eq};
            ALU_LT:   value = {{(XLEN-1){1'b0}}, lt_s};
            ALU_GE:   value = {{(XLEN-1){1'b0}}, ~lt_s};
            ALU_LTU:  value = {{(XLEN-1){1'b0}}, lt_u};
            ALU_GEU:  value = {{(XLEN-1){1'b0}}, ~lt_u};
            default:  value = '0;
        endcase
    end
endmodule

// File: rtl/alu_exec_pipe.sv
// Fixed-latency ALU execution pipe between RS and ROB/CDB; freezes on rdy_in=0,
// drops all in-flight ops on clear_signal. ALU_PERF_CNT_EN adds op_count_out.
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int LATENCY   = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 busy_in,
    input  logic [3:0]           opcode_in,
    input  logic [XLEN-1:0]      lhs_in,
    input  logic [XLEN-1:0]      rhs_in,
    input  logic [ROB_WIDTH-1:0] rd_tag_in,
    output logic                 done_out,
    output logic [XLEN-1:0]      value_out,
    output logic [ROB_WIDTH-1:0] tag_out,
    output logic                 idle_out
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0]          op_count_out
`endif
);
    logic [LATENCY-1:0]                vld_pipe;
    logic [LATENCY-1:0][XLEN-1:0]      val_pipe;
    logic [LATENCY-1:0][ROB_WIDTH-1:0] tag_pipe;
    logic [XLEN-1:0]                   alu_res;

    alu_datapath u_dp (
        .opcode (opcode_in),
        .lhs    (lhs_in),
        .rhs    (rhs_in),
        .value  (alu_res)
    );

    // Payload keeps shifting during a flush; only the valid bits are killed.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_pipe <= '0;
            val_pipe <= '0;
            tag_pipe <= '0;
        end else if (rdy_in) begin
            vld_pipe[0] <= busy_in & ~clear_signal;
            val_pipe[0] <= alu_res;
            tag_pipe[0] <= rd_tag_in;
            for (int k = 1; k < LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1] & ~clear_signal;
                val_pipe[k] <= val_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign done_out  = vld_pipe[LATENCY-1];
    assign value_out = val_pipe[LATENCY-1];
    assign tag_out   = tag_pipe[LATENCY-1];
    assign idle_out  = ~|vld_pipe;

`ifdef ALU_PERF_CNT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            op_count_out <= '0;
        else if (rdy_in && done_out)
            op_count_out <= op_count_out + 32'd1;
    end
`endif
endmodule

// File: tb/tb_alu_exec_pipe.sv
// Scoreboard bench for alu_exec_pipe: driver pushes reference results, a
// negedge monitor pops them whenever a result is consumed.
module tb_alu_exec_pipe;
    localparam int LAT = 2;
    localparam int RW  = 4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          clear_signal = 1'b0;
    logic          busy_in = 1'b0;
    logic [3:0]    opcode_in = '0;
    logic [31:0]   lhs_in = '0;
    logic [31:0]   rhs_in = '0;
    logic [RW-1:0] rd_tag_in = '0;
    logic          done_out;
    logic [31:0]   value_out;
    logic [RW-1:0] tag_out;
    logic          idle_out;
`ifdef ALU_PERF_CNT_EN
    logic [31:0]   op_count_out;
`endif

    alu_exec_pipe #(.ROB_WIDTH(RW), .LATENCY(LAT)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_signal (clear_signal),
        .busy_in      (busy_in),
        .opcode_in    (opcode_in),
        .lhs_in       (lhs_in),
        .rhs_in       (rhs_in),
        .rd_tag_in    (rd_tag_in),
        .done_out     (done_out),
        .value_out    (value_out),
        .tag_out      (tag_out),
        .idle_out     (idle_out)
`ifdef ALU_PERF_CNT_EN
        ,
        .op_count_out (op_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0]   v;
        logic [RW-1:0] t;
        int            c;
    } exp_t;

    exp_t  q[$];
    int    total = 0;
    int    passed = 0;
    int    rdy_cnt = 0;
    int    perf_model = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    endtask

    // Reference semantics written straight from the opcode table.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        int unsigned sh;
        sa = a; sb = b; sh = b % 32;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return sa >>> sh;
            8:  return a | b;
            9:  return a & b;
            10: return (a == b) ? 32'd1 : 32'd0;
            11: return (a != b) ? 32'd1 : 32'd0;
            12: return (sa < sb) ? 32'd1 : 32'd0;
            13: return (sa >= sb) ? 32'd1 : 32'd0;
            14: return (a < b) ? 32'd1 : 32'd0;
            default: return (a >= b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic drive(input logic b, input logic [3:0] op, input logic [31:0] l,
                         input logic [31:0] r, input logic [RW-1:0] t,
                         input logic c, input logic rd);
        exp_t e;
        busy_in = b; opcode_in = op; lhs_in = l; rhs_in = r; rd_tag_in = t;
        clear_signal = c; rdy_in = rd;
        @(posedge clk_in);
        #1;
        if (rd) begin
            rdy_cnt++;
            if (c) q.delete();
            else if (b) begin
                e.v = ref_alu(op, l, r); e.t = t; e.c = rdy_cnt;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b0, 1'b1);
    endtask

    // Monitor: a result is consumed at each rdy-high edge it is visible on.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                chk("idle", {63'd0, idle_out}, {63'd0, q.size() == 0});
                if (done_out && rdy_in) begin
                    perf_model++;
                    if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                    else begin
                        e = q.pop_front();
                        chk("value", {32'd0, value_out}, {32'd0, e.v});
                        chk("tag", {60'd0, tag_out}, {60'd0, e.t});
                        chk("latency", 64'(rdy_cnt - e.c), 64'(LAT - 1));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] corner [6];
        logic [31:0] a, b;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h1F;

        #12;
        chk("rst_done", {63'd0, done_out}, 64'd0);
        chk("rst_value", {32'd0, value_out}, 64'd0);
        chk("rst_tag", {60'd0, tag_out}, 64'd0);
        chk("rst_idle", {63'd0, idle_out}, 64'd1);
`ifdef ALU_PERF_CNT_EN
        chk("rst_count", {32'd0, op_count_out}, 64'd0);
`endif
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        idle_cycle();

        // Wrap, shift and compare corners
        drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd5, 1'b0, 1'b1);
        idle_cycle(); idle_cycle(); idle_cycle();
        drive(1'b1, 4'd7, 32'h8000_0000, 32'h24, 4'd6, 1'b0, 1'b1);
        drive(1'b1, 4'd14, 32'd1, 32'hFFFF_FFFF, 4'd7, 1'b0, 1'b1);
        drive(1'b1, 4'd12, 32'd1, 32'hFFFF_FFFF, 4'd8, 1'b0, 1'b1);
        idle_cycle(); idle_cycle(); idle_cycle();

        // Throughput: tags 1..4 back to back
        for (int i = 1; i <= 4; i++)
            drive(1'b1, 4'd0, 32'(i * 10), 32'd3, RW'(i), 1'b0, 1'b1);
        idle_cycle(); idle_cycle(); idle_cycle();
        chk("idle_after_burst", {63'd0, idle_out}, 64'd1);

        // Stall with an op in stage 0; inputs during stall must be ignored
        drive(1'b1, 4'd1, 32'd100, 32'd1, 4'd9, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd5, 32'hDEAD, 32'hBEEF, 4'd3, 1'b0, 1'b0);
            chk("stall_done", {63'd0, done_out}, 64'd0);
        end
        idle_cycle(); idle_cycle(); idle_cycle();

        // Flush with both stages full plus a dispatch
        drive(1'b1, 4'd8, 32'hF0, 32'h0F, 4'd1, 1'b0, 1'b1);
        drive(1'b1, 4'd9, 32'hF0, 32'hFF, 4'd2, 1'b0, 1'b1);
        drive(1'b1, 4'd2, 32'h1, 32'h3, 4'd3, 1'b1, 1'b1);
        chk("flush_done", {63'd0, done_out}, 64'd0);
        chk("flush_idle", {63'd0, idle_out}, 64'd1);
        idle_cycle(); idle_cycle(); idle_cycle();

        // Async reset mid-flight
        drive(1'b1, 4'd0, 32'd1, 32'd2, 4'd4, 1'b0, 1'b1);
        drive(1'b1, 4'd0, 32'd3, 32'd4, 4'd5, 1'b0, 1'b1);
        busy_in = 1'b0;
        #2;
        rst_in = 1'b0;
        q.delete();
        perf_model = 0;
        #1;
        chk("async_rst_done", {63'd0, done_out}, 64'd0);
        chk("async_rst_idle", {63'd0, idle_out}, 64'd1);
`ifdef ALU_PERF_CNT_EN
        chk("async_rst_count", {32'd0, op_count_out}, 64'd0);
`endif
        #1;
        rst_in = 1'b1;
        idle_cycle();
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd0, 32'(i), 32'd1, RW'(i), 1'b0, 1'b1);
        idle_cycle(); idle_cycle(); idle_cycle();
`ifdef ALU_PERF_CNT_EN
        chk("count_three", {32'd0, op_count_out}, 64'd3);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, b,
                  RW'($urandom_range(0, 15)), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 6) != 0);
        end
        for (int i = 0; i < LAT + 2; i++) idle_cycle();
        chk("final_idle", {63'd0, idle_out}, 64'd1);
        chk("queue_drained", 64'(q.size()), 64'd0);
`ifdef ALU_PERF_CNT_EN
        chk("final_count", {32'd0, op_count_out}, 64'(perf_model));
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Execution unit on the far end of the RS→ALU dispatch interface: accepts one operation per cycle (busy/opcode/lhs/rhs/rd_tag) and returns done/value/tag after a fixed, parameterised latency.
- Two instances sit between the reservation station and the ROB/CDB. Results feed back into RS/LSB forwarding and into the ROB.
- No backpressure: every dispatch must be accepted.

Parameters:
- ROB_WIDTH, 4, width of the ROB tag.
- LATENCY, 2, cycles from accepted dispatch to done_out; legal range 1..4.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-low.
- rdy_in  input  1  global ready; when low, the whole pipe freezes.
- clear_signal  input  1  misprediction flush.
- busy_in  input  1  dispatch valid (RS busy_alu_x).
- opcode_in  input  4  operation code.
- lhs_in  input  32  operand 1.
- rhs_in  input  32  operand 2.
- rd_tag_in  input  ROB_WIDTH  destination ROB tag.
- done_out  output  1  result valid this cycle (feeds done_alu_x).
- value_out  output  32  result value.
- tag_out  output  ROB_WIDTH  ROB tag of the result.
- idle_out  output  1  high when no operation is in flight.

Behaviour:
- Reset: while rst_in is low, asynchronously clear every stage: valid=0, value=0, tag=0. Outputs during and after reset: done_out=0, value_out=0, tag_out=0, idle_out=1.
- Pipeline structure:
  - Stages 0..LATENCY-1, each holding {valid, value[31:0], tag}.
  - Stage 0 captures the combinational result of the inputs.
  - Stage k captures stage k-1.
  - done_out/value_out/tag_out are driven directly from stage LATENCY-1 registers.
- Latency: a dispatch sampled at posedge P (with rdy_in=1) appears on the outputs after posedge P+LATENCY-1. With LATENCY=1, done_out is high in the cycle right after dispatch.
- Throughput: one op per cycle. Back-to-back dispatches produce back-to-back done pulses in issue order.
- Stage 0 valid <= busy_in & ~clear_signal. A bubble (busy_in=0) propagates as valid=0.
- rdy_in=0: no register changes, inputs ignored, outputs hold their values. When rdy_in returns high, the pipe resumes exactly where it stopped.
- Flush (rdy_in=1 & clear_signal=1 at a posedge):
  - Every stage valid <= 0, including the dispatch presented that cycle.
  - value/tag contents are don't-care.
  - done_out is 0 the following cycle.
  - A done_out already visible in the flush cycle is not retracted; the consumer also sees clear_signal and ignores it.
- idle_out = ~|valid across all stages.
- Opcode encoding (results are 32-bit; wrap-around is silent):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA.
  - 8 OR, 9 AND, 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU.
- Shift amount is rhs_in[4:0]; upper bits are ignored. SRA sign-extends.
- Compare ops (3, 4, 10-15) return 32'd1 if true, else 32'd0. Signed compares are two's complement.
- Simultaneous flush and reset: reset dominates.

Optional Feature:
- Macro ALU_PERF_CNT_EN.
- When defined:
  - Extra output op_count_out, 32 bits, counts posedges where done_out=1 and rdy_in=1.
  - Cleared by reset; not cleared by clear_signal.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit opcode localparams (ALU_ADD .. ALU_GEU) listed above, shared with the decoder/RS;
  - the result-width constant (32).
- Sub-module alu_datapath: purely combinational {opcode, lhs, rhs} → value. The pipe wrapper holds all state.

Test Plan:
- Arithmetic wrap: LATENCY=2, dispatch ADD lhs=0xFFFFFFFF rhs=1 tag=5 → two cycles later done_out=1, value_out=0, tag_out=5, then done_out=0.
- Shifts and compares:
  - SRA lhs=0x80000000 rhs=0x24 (shift 4) → value_out=0xF8000000.
  - LTU lhs=1 rhs=0xFFFFFFFF → 1.
  - LT with the same operands → 0.
- Throughput: 4 consecutive dispatches, tags 1,2,3,4 → 4 consecutive done pulses, tags 1..4 in order; idle_out=1 afterwards.
- Stall: rdy_in low for 3 cycles with an op in stage 0 → outputs frozen; done appears exactly LATENCY rdy-high cycles after dispatch.
- Flush: ops in both stages plus a dispatch with clear_signal=1 → next cycle done_out=0, idle_out=1; no later done pulses.
- Reset: rst_in pulsed low asynchronously mid-flight (between clock edges) → done_out=0 and idle_out=1 immediately. With ALU_PERF_CNT_EN, op_count_out=0 after reset and equals 3 after three completed ops.
